// File: rtl/trapez_peak_detector_pkg.sv
// Shared settings for the trapezoidal-shaper back end.
// Holds the data-path widths, the peak detector state encoding and the
// emitted event record layout.
package package_settings;

  localparam int SIZE_SHAPER_DATA          = 16;
  localparam int SIZE_TIME_MAXIMUM_SEARCH  = 8;
  localparam int SIZE_COUNTER_PILE_UP_TIME = 9;
  localparam int SIZE_WORK_TIME            = 64;
  localparam int SIZE_EVENT_COUNTER        = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEARCH  = 2'd1,
    HOLDOFF = 2'd2
  } peak_state_t;

  // 'time' is a reserved word, so the timestamp field is time_tag.
  typedef struct packed {
    logic signed [SIZE_SHAPER_DATA-1:0] amplitude;
    logic [SIZE_WORK_TIME-1:0]          time_tag;
    logic                               pile_up;
  } peak_event_t;

endpackage

// File: rtl/trapez_peak_detector_if.sv
// Sample stream in / event stream out of the peak detector.
//   data_in, data_in_valid                          : shaper samples
//   peak_amplitude, peak_time, pile_up_flag,
//   peak_valid                                      : one event record
// master = shaper/consumer side, slave = the detector.
interface trapez_peak_detector_if;
  import package_settings::*;

  logic signed [SIZE_SHAPER_DATA-1:0] data_in;
  logic                               data_in_valid;
  logic signed [SIZE_SHAPER_DATA-1:0] peak_amplitude;
  logic [SIZE_WORK_TIME-1:0]          peak_time;
  logic                               pile_up_flag;
  logic                               peak_valid;

  modport master (
    output data_in, data_in_valid,
    input  peak_amplitude, peak_time, pile_up_flag, peak_valid
  );

  modport slave (
    input  data_in, data_in_valid,
    output peak_amplitude, peak_time, pile_up_flag, peak_valid
  );

endinterface

// File: rtl/trapez_peak_detector_work_time_counter.sv
// work_time_counter: free-running timestamp, +1 every clk, wraps to 0.
//   clk, reset (async, active-low) in; work_time out.
module work_time_counter #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] work_time
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) work_time <= '0;
    else        work_time <= work_time + WIDTH'(1);
  end

endmodule

// File: rtl/trapez_peak_detector.sv
// trapez_peak_detector: one amplitude per shaper pulse.
// Triggers on a rising threshold crossing, takes the signed maximum over a
// search window of valid samples, then holds off for a pile-up interval and
// emits {amplitude, timestamp, pile-up} as a one-cycle strobe.
//   clk, reset (async, active-low)
//   enable, threshold, search_time, pile_up_time : configuration
//   bus (slave)                                   : sample in / event out
//   event_counter, pile_up_counter                : emitted event counts
module trapez_peak_detector
  import package_settings::*;
(
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 enable,
  input  logic signed [SIZE_SHAPER_DATA-1:0]   threshold,
  input  logic [SIZE_TIME_MAXIMUM_SEARCH-1:0]  search_time,
  input  logic [SIZE_COUNTER_PILE_UP_TIME-1:0] pile_up_time,
  trapez_peak_detector_if.slave                bus,
  output logic [SIZE_EVENT_COUNTER-1:0]        event_counter,
  output logic [SIZE_EVENT_COUNTER-1:0]        pile_up_counter
);

  localparam int DW = SIZE_SHAPER_DATA;
  localparam int SW = SIZE_TIME_MAXIMUM_SEARCH;
  localparam int PW = SIZE_COUNTER_PILE_UP_TIME;
  localparam int TW = SIZE_WORK_TIME;
  localparam int CW = SIZE_EVENT_COUNTER;

  logic [TW-1:0] work_time;

  work_time_counter #(.WIDTH(TW)) u_work_time (
    .clk       (clk),
    .reset     (reset),
    .work_time (work_time)
  );

  peak_state_t          state, state_d;
  logic signed [DW-1:0] max_q, max_d;
  logic [TW-1:0]        max_time_q, max_time_d;
  logic [SW-1:0]        win_cnt_q, win_cnt_d, search_len_q, search_len_d;
  logic [PW-1:0]        hold_cnt_q, hold_cnt_d, hold_len_q, hold_len_d;
  logic                 pile_q, pile_d;
  logic                 above_prev, above, rising, emit;
  logic [SW-1:0]        search_eff;
  peak_event_t          evt_q;
  logic                 peak_valid_q;

  assign above      = bus.data_in > threshold;
  assign rising     = bus.data_in_valid && above && !above_prev;
  // A zero window still contains the trigger sample.
  assign search_eff = (search_time == '0) ? SW'(1) : search_time;

  always_comb begin
    state_d      = state;
    max_d        = max_q;
    max_time_d   = max_time_q;
    win_cnt_d    = win_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    search_len_d = search_len_q;
    hold_len_d   = hold_len_q;
    pile_d       = pile_q;
    emit         = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable && rising) begin
          max_d        = bus.data_in;
          max_time_d   = work_time;
          win_cnt_d    = SW'(1);
          hold_cnt_d   = '0;
          pile_d       = 1'b0;
          search_len_d = search_eff;
          hold_len_d   = pile_up_time;
          // Trigger sample alone may already fill the window.
          if (search_eff == SW'(1)) begin
            if (pile_up_time == '0) emit = 1'b1;
            else                    state_d = HOLDOFF;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (bus.data_in_valid) begin
          if (bus.data_in > max_q) begin
            max_d      = bus.data_in;
            max_time_d = work_time;
          end
          if (rising) pile_d = 1'b1;
          win_cnt_d = win_cnt_q + SW'(1);
          if (win_cnt_d == search_len_q) begin
            hold_cnt_d = '0;
            if (hold_len_q == '0) begin
              emit    = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = HOLDOFF;
            end
          end
        end
      end
      HOLDOFF: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (bus.data_in_valid) begin
          if (rising) pile_d = 1'b1;
          hold_cnt_d = hold_cnt_q + PW'(1);
          if (hold_cnt_d == hold_len_q) begin
            emit    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q           <= '0;
      max_time_q      <= '0;
      win_cnt_q       <= '0;
      hold_cnt_q      <= '0;
      search_len_q    <= '0;
      hold_len_q      <= '0;
      pile_q          <= 1'b0;
      above_prev      <= 1'b0;
      evt_q           <= '0;
      peak_valid_q    <= 1'b0;
      event_counter   <= '0;
      pile_up_counter <= '0;
    end else begin
      max_q        <= max_d;
      max_time_q   <= max_time_d;
      win_cnt_q    <= win_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      search_len_q <= search_len_d;
      hold_len_q   <= hold_len_d;
      pile_q       <= pile_d;
      // Crossing history tracks the stream regardless of state/enable.
      if (bus.data_in_valid) above_prev <= above;
      peak_valid_q <= emit;
      if (emit) begin
        evt_q         <= '{amplitude: max_d, time_tag: max_time_d, pile_up: pile_d};
        event_counter <= event_counter + CW'(1);
        if (pile_d) pile_up_counter <= pile_up_counter + CW'(1);
      end
    end
  end

  assign bus.peak_amplitude = evt_q.amplitude;
  assign bus.peak_time      = evt_q.time_tag;
  assign bus.pile_up_flag   = evt_q.pile_up;
  assign bus.peak_valid     = peak_valid_q;

endmodule
